// File: rtl/ftc_multi_rank_synchronizer_filt.sv
// Multi-rank CDC synchronizer bank with a per-bit stability filter, rise/fall
// event pulses and a single-cycle test-mode bypass.
module ftc_multi_rank_synchronizer_filt #(
  parameter int               WIDTH       = 1,
  parameter int               STAGES      = 2,
  parameter logic [WIDTH-1:0] RSTVAL      = {WIDTH{1'b0}},
  parameter int               FILT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             test_mode_async,
  input  logic             filt_en,
  input  logic [WIDTH-1:0] async_data,
  output logic [WIDTH-1:0] sync_data,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  localparam int              CW          = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_MAX     = CW'(FILT_CYCLES - 1);
  localparam bit              FILT_ACTIVE = (FILT_CYCLES > 1);

  generate
    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
      $error("ftc_multi_rank_synchronizer_filt: STAGES must be 2..4");
    end
    if (FILT_CYCLES < 1 || FILT_CYCLES > 255) begin : g_bad_filt
      $error("ftc_multi_rank_synchronizer_filt: FILT_CYCLES must be 1..255");
    end
  endgenerate

  logic [STAGES-1:0][WIDTH-1:0] rank_q, rank_d;
  logic [WIDTH-1:0][CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]             sync_q, sync_d;
  logic [WIDTH-1:0]             rise_q, rise_d;
  logic [WIDTH-1:0]             fall_q, fall_d;
  logic [WIDTH-1:0]             s_last;

  assign s_last = rank_q[STAGES-1];

  always_comb begin
    rank_d = rank_q;
    sync_d = sync_q;
    cnt_d  = cnt_q;

    if (test_mode_async) begin
      for (int k = 0; k < STAGES; k++) begin
        rank_d[k] = async_data;
      end
      sync_d = async_data;
      cnt_d  = '0;
    end else begin
      rank_d[0] = async_data;
      for (int k = 1; k < STAGES; k++) begin
        rank_d[k] = rank_q[k-1];
      end
      // A bit's counter runs only while the last rank disagrees with the output;
      // any agreement discards the partial count.
      for (int i = 0; i < WIDTH; i++) begin
        if (!filt_en || !FILT_ACTIVE) begin
          sync_d[i] = s_last[i];
          cnt_d[i]  = '0;
        end else if (s_last[i] == sync_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          sync_d[i] = s_last[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end

    rise_d = sync_d & ~sync_q;
    fall_d = ~sync_d & sync_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rank_q <= {STAGES{RSTVAL}};
      sync_q <= RSTVAL;
      cnt_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rank_q <= rank_d;
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign sync_data  = sync_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

endmodule

// File: tb/tb_ftc_multi_rank_synchronizer_filt.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a delay-line/run-length model.
module tb_ftc_multi_rank_synchronizer_filt;

  localparam int         W  = 4;
  localparam int         S  = 3;
  localparam int         F  = 4;
  localparam logic [W-1:0] RV = 4'b0101;

  logic         clk = 1'b0;
  logic         rst;
  logic         test_mode_async;
  logic         filt_en;
  logic [W-1:0] async_data;
  logic [W-1:0] sync_data;
  logic [W-1:0] rise_pulse;
  logic [W-1:0] fall_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  ftc_multi_rank_synchronizer_filt #(
    .WIDTH(W), .STAGES(S), .RSTVAL(RV), .FILT_CYCLES(F)
  ) dut (
    .clk(clk), .rst(rst), .test_mode_async(test_mode_async), .filt_en(filt_en),
    .async_data(async_data), .sync_data(sync_data),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: the ranks are a plain delay line of input samples, the
  // filter is a per-bit run length of consecutive disagreeing cycles.
  logic [W-1:0] line [S];
  int           run  [W];
  logic [W-1:0] m_sync, m_rise, m_fall;
  bit           model_valid = 1'b0;

  always @(posedge clk) begin
    logic [W-1:0] old_last;
    logic [W-1:0] nxt;
    if (rst) begin
      for (int k = 0; k < S; k++) line[k] = RV;
      for (int i = 0; i < W; i++) run[i] = 0;
      m_sync = RV; m_rise = '0; m_fall = '0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      nxt = m_sync;
      if (test_mode_async) begin
        for (int k = 0; k < S; k++) line[k] = async_data;
        for (int i = 0; i < W; i++) run[i] = 0;
        nxt = async_data;
      end else begin
        old_last = line[S-1];
        for (int i = 0; i < W; i++) begin
          if (!filt_en) begin
            nxt[i] = old_last[i]; run[i] = 0;
          end else if (old_last[i] == m_sync[i]) begin
            run[i] = 0;
          end else if (run[i] + 1 >= F) begin
            nxt[i] = old_last[i]; run[i] = 0;
          end else begin
            run[i] = run[i] + 1;
          end
        end
        for (int k = S-1; k > 0; k--) line[k] = line[k-1];
        line[0] = async_data;
      end
      m_rise = nxt & ~m_sync;
      m_fall = ~nxt & m_sync;
      m_sync = nxt;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      n_checks++;
      if ({sync_data, rise_pulse, fall_pulse} !== {m_sync, m_rise, m_fall}) begin
        n_fail++;
        $display("[TB] FAIL model_cmp t=%0t: sync/rise/fall got %b/%b/%b want %b/%b/%b",
                 $time, sync_data, rise_pulse, fall_pulse, m_sync, m_rise, m_fall);
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic tm, input logic fe,
                               input logic [W-1:0] d);
    rst = r; test_mode_async = tm; filt_en = fe; async_data = d;
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] es,
                             input logic [W-1:0] er, input logic [W-1:0] ef);
    n_checks++;
    if ({sync_data, rise_pulse, fall_pulse} !== {es, er, ef}) begin
      n_fail++;
      $display("[TB] FAIL %s: sync/rise/fall got %b/%b/%b want %b/%b/%b",
               name, sync_data, rise_pulse, fall_pulse, es, er, ef);
    end
  endtask

  initial begin
    logic [W-1:0] cur;
    logic         fe, tm, r;
    int           tm_left;

    // Scenario 1: reset and first release
    applyStimulus(1'b1, 1'b0, 1'b1, 4'b1010);
    waitEdges(1); checkOutput("rst_edge1", RV, 4'b0000, 4'b0000);
    waitEdges(1); checkOutput("rst_edge2", RV, 4'b0000, 4'b0000);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b1010);
    waitEdges(1); checkOutput("rst_release", RV, 4'b0000, 4'b0000);
    waitEdges(5); checkOutput("rst_edge5", RV, 4'b0000, 4'b0000);
    waitEdges(1); checkOutput("rst_edge6", 4'b1010, 4'b1010, 4'b0101);
    waitEdges(1); checkOutput("rst_edge7", 4'b1010, 4'b0000, 4'b0000);

    // Scenario 2: filtered step on bit0
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000);
    waitEdges(10); checkOutput("step_settle", 4'b0000, 4'b0000, 4'b0000);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b0001);
    waitEdges(6); checkOutput("step_edge5", 4'b0000, 4'b0000, 4'b0000);
    waitEdges(1); checkOutput("step_edge6", 4'b0001, 4'b0001, 4'b0000);
    waitEdges(1); checkOutput("step_edge7", 4'b0001, 4'b0000, 4'b0000);

    // Scenario 3: 3-cycle glitch rejected, 4-cycle pulse accepted
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000);
    waitEdges(10);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b0010);
    waitEdges(3);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000);
    for (int e = 0; e < 8; e++) begin
      waitEdges(1); checkOutput("glitch_reject", 4'b0000, 4'b0000, 4'b0000);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b0010);
    waitEdges(4);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b0000);
    waitEdges(3); checkOutput("glitch_accept_e6", 4'b0010, 4'b0010, 4'b0000);
    waitEdges(3); checkOutput("glitch_hold_e9", 4'b0010, 4'b0000, 4'b0000);
    waitEdges(1); checkOutput("glitch_fall_e10", 4'b0000, 4'b0000, 4'b0010);

    // Scenario 4: filter disabled, bit2 falls with rank latency only
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b0100);
    waitEdges(10);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0000);
    waitEdges(3); checkOutput("nofilt_e2", 4'b0100, 4'b0000, 4'b0000);
    waitEdges(1); checkOutput("nofilt_e3", 4'b0000, 4'b0000, 4'b0100);
    waitEdges(1); checkOutput("nofilt_e4", 4'b0000, 4'b0000, 4'b0000);

    // Scenario 5: test-mode bypass and clean exit
    applyStimulus(1'b0, 1'b1, 1'b1, 4'b0011);
    waitEdges(1); checkOutput("tm_first", 4'b0011, 4'b0011, 4'b0000);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'b1100);
    waitEdges(1); checkOutput("tm_swap", 4'b1100, 4'b1100, 4'b0011);
    waitEdges(1); checkOutput("tm_hold", 4'b1100, 4'b0000, 4'b0000);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b1100);
    for (int e = 0; e < 8; e++) begin
      waitEdges(1); checkOutput("tm_exit", 4'b1100, 4'b0000, 4'b0000);
    end

    // Scenario 6: reset in the middle of a bit3 count
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b0101);
    waitEdges(10);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b1101);
    waitEdges(5);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'b1101);
    waitEdges(1); checkOutput("midrst_edge", RV, 4'b0000, 4'b0000);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b1101);
    waitEdges(6); checkOutput("midrst_r5", RV, 4'b0000, 4'b0000);
    waitEdges(1); checkOutput("midrst_r6", 4'b1101, 4'b1000, 4'b0000);

    // Randomized run against the model
    cur = 4'b1101; fe = 1'b1; tm = 1'b0; tm_left = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < W; i++) begin
        if ($urandom_range(0, 5) == 0) cur[i] = ~cur[i];
      end
      if ($urandom_range(0, 39) == 0) fe = ~fe;
      if (tm_left > 0) tm_left--;
      else if ($urandom_range(0, 99) == 0) tm_left = $urandom_range(1, 6);
      tm = (tm_left > 0);
      r  = ($urandom_range(0, 299) == 0);
      applyStimulus(r, tm, fe, cur);
      waitEdges(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
